// File: rtl/matrix_column_scanner.sv
// Multiplexed 5x7 LED matrix column scanner with per-frame shadow latching and blanking.
// Optional blink support is compiled in with the MATRIX_BLINK_EN macro.
module matrix_column_scanner #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned BLANK = 2
`ifdef MATRIX_BLINK_EN
   ,
   parameter int unsigned BLINK_FRAMES = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
`ifdef MATRIX_BLINK_EN
   input  logic       blink,
`endif
   input  logic [6:0] column_4,
   input  logic [6:0] column_3,
   input  logic [6:0] column_2,
   input  logic [6:0] column_1,
   input  logic [6:0] column_0,
   output logic [4:0] column_select,
   output logic [6:0] row_data,
   output logic       frame_start
);

   localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK);

   typedef enum logic [0:0] {StIdle, StScan} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     div_cnt_q, div_cnt_d;
   logic [2:0]          index_q, index_d;
   logic [4:0][6:0]     shadow_q, shadow_d;
   logic [4:0]          column_select_d;
   logic [6:0]          row_data_d;
   logic                frame_start_d;
   logic [6:0]          sel_row;
   logic [4:0][6:0]     columns;

`ifdef MATRIX_BLINK_EN
   localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FcW-1:0] LastFrame = FcW'(BLINK_FRAMES - 1);

   logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
   logic           phase_q, phase_d;
`endif

   assign columns = {column_4, column_3, column_2, column_1, column_0};

   always_comb begin
      sel_row = '0;
      case (index_q)
         3'd0: sel_row = shadow_q[0];
         3'd1: sel_row = shadow_q[1];
         3'd2: sel_row = shadow_q[2];
         3'd3: sel_row = shadow_q[3];
         3'd4: sel_row = shadow_q[4];
         default: sel_row = '0;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      div_cnt_d       = div_cnt_q;
      index_d         = index_q;
      shadow_d        = shadow_q;
      column_select_d = 5'b11111;
      row_data_d      = '0;
      frame_start_d   = 1'b0;
`ifdef MATRIX_BLINK_EN
      frame_cnt_d     = frame_cnt_q;
      phase_d         = phase_q;
`endif
      case (state_q)
         StIdle: begin
            if (enable) begin
               state_d       = StScan;
               div_cnt_d     = '0;
               index_d       = 3'd4;
               shadow_d      = columns;
               frame_start_d = 1'b1;
`ifdef MATRIX_BLINK_EN
               frame_cnt_d   = '0;
               phase_d       = 1'b0;
`endif
            end
         end
         StScan: begin
            if (!enable) begin
               // Outputs already default to off; partial frames are abandoned.
               state_d   = StIdle;
               div_cnt_d = '0;
               index_d   = 3'd4;
            end else begin
               if (div_cnt_q >= BlankCnt) begin
                  column_select_d = ~(5'b00001 << index_q);
                  row_data_d      = sel_row;
`ifdef MATRIX_BLINK_EN
                  if (blink && phase_q) row_data_d = '0;
`endif
               end
               if (div_cnt_q == LastCnt) begin
                  div_cnt_d = '0;
                  if (index_q == 3'd0) begin
                     index_d       = 3'd4;
                     shadow_d      = columns;
                     frame_start_d = 1'b1;
`ifdef MATRIX_BLINK_EN
                     if (frame_cnt_q == LastFrame) begin
                        frame_cnt_d = '0;
                        phase_d     = ~phase_q;
                     end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                     end
`endif
                  end else begin
                     index_d = index_q - 3'd1;
                  end
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end
            end
`ifdef MATRIX_BLINK_EN
            // Blink off means continuous display and a fresh blink cycle next time.
            if (!blink) begin
               frame_cnt_d = '0;
               phase_d     = 1'b0;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         div_cnt_q     <= '0;
         index_q       <= 3'd4;
         shadow_q      <= '0;
         column_select <= 5'b11111;
         row_data      <= '0;
         frame_start   <= 1'b0;
`ifdef MATRIX_BLINK_EN
         frame_cnt_q   <= '0;
         phase_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         index_q       <= index_d;
         shadow_q      <= shadow_d;
         column_select <= column_select_d;
         row_data      <= row_data_d;
         frame_start   <= frame_start_d;
`ifdef MATRIX_BLINK_EN
         frame_cnt_q   <= frame_cnt_d;
         phase_q       <= phase_d;
`endif
      end
   end

endmodule

// File: doc/matrix_column_scanner.md
MATRIX_COLUMN_SCANNER -- requirements
Module: matrix_column_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 Parameter SCAN_DIV SHALL default to 50000 and SHALL set the clk cycles per column slot.
REQ-003 Parameter BLANK SHALL default to 2 and SHALL set the blanking cycles at the start of each slot; the legal range SHALL be 0 <= BLANK < SCAN_DIV.
REQ-004 The port list SHALL be, clock and reset first:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- enable  input  1  scan enable, level-sensitive
- column_4..column_0  input  7 each  column images; bit r = 1 lights row r
- column_select  output  5  one-hot column drive, active-low; bit k drives column k
- row_data  output  7  row drive for the selected column, active-high
- frame_start  output  1  one-cycle pulse when a new frame is latched

Function
REQ-005 The state machine SHALL have two states, IDLE and SCAN.
REQ-006 Registered outputs: every output SHALL come from a flip-flop, and no combinational path SHALL run from any input to any output.
REQ-007 In IDLE, outputs SHALL be column_select = 5'b11111, row_data = 7'b0000000 and frame_start = 0.
REQ-008 IDLE to SCAN: on the edge where enable = 1 in IDLE, the block SHALL enter SCAN, set div_cnt = 0 and slot index = 4, latch all five columns into a shadow buffer, and assert frame_start on the next cycle.
REQ-009 Prescaler: div_cnt SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-010 When div_cnt wraps, the slot index SHALL step in the order 4, 3, 2, 1, 0, 4, and so on.
REQ-011 Blanking: while div_cnt < BLANK, the block SHALL drive column_select = 5'b11111 and row_data = 0.
REQ-012 While div_cnt >= BLANK, column_select bit [index] SHALL be 0, the other bits SHALL be 1, and row_data SHALL equal shadow[index].
REQ-013 Outputs SHALL reflect div_cnt and index with exactly one cycle of latency.
REQ-014 Frame boundary: when index wraps from 0 to 4, the block SHALL re-latch the shadow buffer from the inputs on the same edge and pulse frame_start for one cycle.
REQ-015 A frame SHALL last 5*SCAN_DIV cycles.
REQ-016 No tearing: input changes during a frame SHALL NOT affect row_data until the next frame boundary.
REQ-017 At most one column_select bit SHALL ever be low; column_select = 5'b00000 or any two-low pattern SHALL never occur.
REQ-018 SCAN to IDLE: enable = 0 in SCAN SHALL return the block to IDLE on that edge, and the outputs SHALL be off on the following cycle, regardless of div_cnt or index.
REQ-019 Re-enable SHALL always restart at index 4 with a fresh latch; partial frames SHALL NOT resume.
REQ-020 If BLANK = 0, no blanking cycles SHALL be inserted and each column SHALL be shown for all SCAN_DIV cycles.

Reset
REQ-021 On the reset edge the block SHALL set state = IDLE, div_cnt = 0, index = 4, shadow = 0, column_select = 5'b11111, row_data = 0 and frame_start = 0.
REQ-022 Reset SHALL take priority over enable.
REQ-023 Reset asserted mid-scan SHALL give IDLE outputs on the next cycle.

Configuration
REQ-024 The macro MATRIX_BLINK_EN SHALL control blink support.
REQ-025 With MATRIX_BLINK_EN defined, the block SHALL add an input blink (1 bit) and a parameter BLINK_FRAMES (default 32), and SHALL keep a frame counter that toggles a phase flag every BLINK_FRAMES frame boundaries.
REQ-026 With MATRIX_BLINK_EN defined and blink = 1 with the phase flag set, row_data SHALL be forced to 0 while column timing, column_select and frame_start continue unchanged.
REQ-027 With MATRIX_BLINK_EN defined and blink = 0, the phase flag SHALL clear and the display SHALL be continuous.
REQ-028 With MATRIX_BLINK_EN defined, reset SHALL clear the frame counter and the phase flag.
REQ-029 Without MATRIX_BLINK_EN, the blink port, counter and phase flag SHALL NOT exist and the behaviour SHALL be exactly that of REQ-005 to REQ-023.

Verification
REQ-030 The bench SHALL cover these directed scenarios, all with SCAN_DIV = 8 and BLANK = 2:
- Reset: hold reset with enable = 1 for 3 cycles -> column_select = 11111, row_data = 0000000, frame_start = 0 throughout.
- Basic scan: enable = 1 with column_4 = 1111011, column_3 = 1111101, column_2 = 0000000 -> frame_start is high one cycle; then 2 blank cycles; then column_select = 01111 and row_data = 1111011 for 6 cycles; then 2 blank cycles; then column_select = 10111 and row_data = 1111101; frame_start repeats every 40 cycles.
- No tearing: change column_4 to 1100011 at cycle 10 of a frame -> row_data shows 1111011 for column 4 until the next frame_start, then 1100011.
- Enable drop: drop enable in the column 2 slot -> all outputs off the next cycle; re-raise enable -> frame_start, then column 4 first.
- Mid-scan reset: assert reset in the column 1 slot -> IDLE outputs the next cycle, and no frame_start until enable is seen after reset releases.
- Blink (MATRIX_BLINK_EN, BLINK_FRAMES = 2, blink = 1): frames 0-1 lit, frames 2-3 row_data = 0 with column_select still cycling, frames 4-5 lit.
